// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, debounces whole-frame
// results and shifts accepted digits into an 8-digit BCD entry register.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [31:0] BCD_out
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  state_t             state, state_n;
  logic [DEB_W-1:0]   cnt, cnt_n;
  logic [3:0]         cand, cand_n;
  logic               commit;

  logic [3:0]         col_meta, col_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         row;
  logic               row_end, frame_end;

  logic [1:0]         acc_cnt;
  logic [3:0]         acc_code;
  logic [3:0]         row_hits;
  logic [2:0]         row_pop;
  logic [1:0]         col_idx;
  logic [1:0]         tot_cnt;
  logic [3:0]         tot_code;
  logic               res_none, res_single;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign row_out   = ~(4'b0001 << row);
  assign row_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = row_end && (row == 2'd3);
  assign key_held  = (state == PRESSED) || (state == DEB_RELEASE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_meta <= '0;
      col_sync <= '0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Free-running row scan; the FSM never stalls it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      row     <= '0;
    end else if (row_end) begin
      div_cnt <= '0;
      row     <= row + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign row_hits = ~col_sync;

  always_comb begin
    row_pop = {2'b00, row_hits[0]} + {2'b00, row_hits[1]}
            + {2'b00, row_hits[2]} + {2'b00, row_hits[3]};
    col_idx = 2'd3;
    if (row_hits[0])      col_idx = 2'd0;
    else if (row_hits[1]) col_idx = 2'd1;
    else if (row_hits[2]) col_idx = 2'd2;
  end

  // Running frame tally including this row's sample; count saturates at 2 (= MULTI).
  always_comb begin
    tot_cnt  = acc_cnt;
    tot_code = acc_code;
    if (row_pop != 3'd0) begin
      if (acc_cnt == 2'd0 && row_pop == 3'd1) begin
        tot_cnt  = 2'd1;
        tot_code = key_map(row, col_idx);
      end else begin
        tot_cnt  = 2'd2;
      end
    end
  end

  assign res_none   = (tot_cnt == 2'd0);
  assign res_single = (tot_cnt == 2'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (frame_end) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (row_end) begin
      acc_cnt  <= tot_cnt;
      acc_code <= tot_code;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  // MULTI counts as absent while idle/debouncing a press, but as present once held.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    commit  = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (res_single) begin
            state_n = DEB_PRESS;
            cand_n  = tot_code;
            cnt_n   = DEB_W'(1);
          end
        end
        DEB_PRESS: begin
          if (res_single && tot_code == cand) begin
            if (cnt == DEB_W'(DEBOUNCE - 1)) begin
              state_n = PRESSED;
              commit  = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (res_none) begin
            state_n = DEB_RELEASE;
            cnt_n   = DEB_W'(1);
          end
        end
        DEB_RELEASE: begin
          if (res_none) begin
            if (cnt == DEB_W'(DEBOUNCE - 1)) state_n = IDLE;
            else                             cnt_n   = cnt + 1'b1;
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // '#' backspaces, '*' clears, digits shift in at the low end, A-D only pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      BCD_out   <= '0;
    end else begin
      key_valid <= commit;
      if (commit) begin
        key_code <= cand;
        if (cand <= 4'd9)       BCD_out <= {BCD_out[27:0], cand};
        else if (cand == 4'hF)  BCD_out <= {4'h0, BCD_out[31:4]};
        else if (cand == 4'hE)  BCD_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad model, directed segment table,
// reset-while-held sequence and randomized frames against a frame-level reference.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [31:0] BCD_out;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          errors = 0;
  int          pulse_count = 0;

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic [31:0] bcd;
    bit          held;
  } seg_t;

  seg_t        segs[$];

  logic [3:0]  keymap[16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0]  row_pat[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int          m_run, m_rel;
  bit          m_held;
  logic [3:0]  m_cand, m_code;
  longint      m_num;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock     (clock),
    .reset     (reset),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .BCD_out   (BCD_out)
  );

  // Passive keypad: a column reads low when its pressed key sits on the driven row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end

  always @(negedge clock) if (key_valid === 1'b1) pulse_count++;

  function automatic logic [31:0] to_bcd(input longint n);
    logic [31:0] b;
    longint      v;
    b = '0;
    v = n;
    for (int i = 0; i < 8; i++) begin
      b[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_run = 0; m_rel = 0; m_held = 0; m_cand = '0; m_code = '0; m_num = 0;
  endtask

  // Entry register kept as a decimal number: typing multiplies by ten, '#' divides.
  task automatic model_frame(input logic [15:0] mask, output bit commit);
    int         n;
    logic [3:0] code;
    n = $countones(mask);
    code = '0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = keymap[i];
    commit = 1'b0;
    if (!m_held) begin
      if (m_run > 0) begin
        if (n == 1 && code == m_cand) m_run++;
        else                          m_run = 0;
      end else if (n == 1) begin
        m_cand = code;
        m_run  = 1;
      end
      if (m_run == DEBOUNCE) begin
        commit = 1'b1;
        m_held = 1'b1;
        m_rel  = 0;
        m_run  = 0;
        m_code = m_cand;
        if (m_cand <= 4'd9)      m_num = (m_num * 10 + longint'(m_cand)) % 100000000;
        else if (m_cand == 4'hF) m_num = m_num / 10;
        else if (m_cand == 4'hE) m_num = 0;
      end
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == DEBOUNCE) m_held = 1'b0;
      end else begin
        m_rel = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Holds a key pattern for one whole frame, then checks against the reference.
  task automatic applyStimulus(input logic [15:0] mask);
    int pc;
    bit commit;
    pressed = mask;
    pc = pulse_count;
    repeat (FRAME) @(posedge clock);
    @(negedge clock);
    #1;
    model_frame(mask, commit);
    checkOutput("frame_pulses", 32'(pulse_count - pc), 32'(commit));
    checkOutput("frame_code", {28'b0, key_code}, {28'b0, m_code});
    checkOutput("frame_bcd", BCD_out, to_bcd(m_num));
    checkOutput("frame_held", {31'b0, key_held}, {31'b0, m_held});
  endtask

  task automatic run_segment(input int idx, input seg_t s);
    int pc;
    pc = pulse_count;
    for (int f = 0; f < s.frames; f++) applyStimulus(s.mask);
    checkOutput($sformatf("seg%0d_pulses", idx), 32'(pulse_count - pc), 32'(s.pulses));
    checkOutput($sformatf("seg%0d_code", idx), {28'b0, key_code}, {28'b0, s.code});
    checkOutput($sformatf("seg%0d_bcd", idx), BCD_out, s.bcd);
    checkOutput($sformatf("seg%0d_held", idx), {31'b0, key_held}, {31'b0, s.held});
  endtask

  task automatic add_seg(input logic [15:0] mask, input int frames, input int pulses,
                         input logic [3:0] code, input logic [31:0] bcd, input bit held);
    seg_t s;
    s.mask = mask; s.frames = frames; s.pulses = pulses;
    s.code = code; s.bcd = bcd; s.held = held;
    segs.push_back(s);
  endtask

  task automatic add_key(input int bitpos, input logic [3:0] code, input logic [31:0] bcd);
    add_seg(16'(1) << bitpos, 3, 1, code, bcd, 1'b1);
    add_seg(16'h0000, 3, 0, code, bcd, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_row"},   {28'b0, row_out},   32'h0000000E);
    checkOutput({tag, "_valid"}, {31'b0, key_valid}, 32'h0);
    checkOutput({tag, "_code"},  {28'b0, key_code},  32'h0);
    checkOutput({tag, "_held"},  {31'b0, key_held},  32'h0);
    checkOutput({tag, "_bcd"},   BCD_out,            32'h0);
  endtask

  initial begin
    int   pc0;
    bit   cm;
    seg_t s;

    // Keys by bit r*4+c: '1'=0 '2'=1 '3'=2 'A'=3 '4'=4 '5'=5 '6'=6 '7'=8 '8'=9 '9'=10 '*'=12 '#'=14
    add_seg(16'h0020, 6, 1, 4'h5, 32'h00000005, 1'b1);
    add_seg(16'h0000, 2, 0, 4'h5, 32'h00000005, 1'b1);
    add_seg(16'h0000, 1, 0, 4'h5, 32'h00000005, 1'b0);
    add_seg(16'h0100, 6, 1, 4'h7, 32'h00000057, 1'b1);
    add_seg(16'h0000, 3, 0, 4'h7, 32'h00000057, 1'b0);
    add_seg(16'h0004, 2, 0, 4'h7, 32'h00000057, 1'b0);
    add_seg(16'h0000, 1, 0, 4'h7, 32'h00000057, 1'b0);
    add_seg(16'h0004, 3, 1, 4'h3, 32'h00000573, 1'b1);
    add_seg(16'h0000, 3, 0, 4'h3, 32'h00000573, 1'b0);
    add_seg(16'h0003, 5, 0, 4'h3, 32'h00000573, 1'b0);
    add_seg(16'h0000, 1, 0, 4'h3, 32'h00000573, 1'b0);
    add_seg(16'h0010, 4, 1, 4'h4, 32'h00005734, 1'b1);
    add_seg(16'h0000, 1, 0, 4'h4, 32'h00005734, 1'b1);
    add_seg(16'h0010, 1, 0, 4'h4, 32'h00005734, 1'b1);
    add_seg(16'h0000, 3, 0, 4'h4, 32'h00005734, 1'b0);
    add_key(0,  4'h1, 32'h00057341);
    add_key(1,  4'h2, 32'h00573412);
    add_key(2,  4'h3, 32'h05734123);
    add_key(4,  4'h4, 32'h57341234);
    add_key(5,  4'h5, 32'h73412345);
    add_key(6,  4'h6, 32'h34123456);
    add_key(8,  4'h7, 32'h41234567);
    add_key(9,  4'h8, 32'h12345678);
    add_key(10, 4'h9, 32'h23456789);
    add_key(14, 4'hF, 32'h02345678);
    add_key(3,  4'hA, 32'h02345678);
    add_key(12, 4'hE, 32'h00000000);
    add_seg(16'h0200, 3, 1, 4'h8, 32'h00000008, 1'b1);

    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    model_reset();

    @(negedge clock);
    reset = 1'b1;
    pc0 = pulse_count;
    for (int k = 0; k < FRAME; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("row_scan%0d", k), {28'b0, row_out}, {28'b0, row_pat[((k + 1) / 4) % 4]});
    end
    @(negedge clock);
    #1;
    model_frame(16'h0000, cm);
    checkOutput("idle_pulses", 32'(pulse_count - pc0), 32'h0);
    checkOutput("idle_bcd", BCD_out, 32'h0);

    foreach (segs[i]) run_segment(i, segs[i]);

    // Reset lands mid-frame while '8' is held; the same key must be re-accepted afterwards.
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    s.mask = 16'h0200; s.frames = 3; s.pulses = 1; s.code = 4'h8; s.bcd = 32'h8; s.held = 1'b1;
    run_segment(100, s);
    s.mask = 16'h0000; s.pulses = 0; s.held = 1'b0;
    run_segment(101, s);

    for (int n = 0; n < 40; n++) begin
      int          kind, nfr, a, b;
      logic [15:0] mask;
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, 15);
      if (kind <= 6) begin
        mask = 16'(1) << a;
        nfr  = $urandom_range(1, 5);
      end else if (kind == 7) begin
        b    = (a + 1 + $urandom_range(0, 14)) % 16;
        mask = (16'(1) << a) | (16'(1) << b);
        nfr  = $urandom_range(1, 3);
      end else begin
        mask = 16'h0000;
        nfr  = $urandom_range(1, 4);
      end
      for (int f = 0; f < nfr; f++) applyStimulus(mask);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
